// File: rtl/mic_axi_sample_writer.sv
// -----------------------------------------------------------------------------
// mic_axi_sample_writer
//
// Collects 16-bit microphone samples over a valid/ready handshake. Each pair
// of samples becomes one 32-bit word, with the first sample of the pair in
// the low half. Packed words wait in a small FIFO and are written to the
// PSRAM AXI4 slave as single-beat bursts at consecutive word addresses. A
// recording is started by a pulse on start and ends after NUM_WORDS write
// responses have been received.
//
// Ports
//   clk, S_AXI_ARESETN     clock and asynchronous active-low reset
//   start                  one-cycle pulse; begins a recording when idle
//   sample_data/valid/ready  incoming mic samples
//   busy                   recording in progress
//   done                   one-cycle pulse after the last write response
//   overflow               sticky: sample offered while it could not be taken
//   wr_err                 sticky: a write response other than OKAY was seen
//   words_written          write responses received in this recording
//   M_AXI_AW*/W*/B*        AXI4 write channels (single beat, INCR, 32-bit)
// -----------------------------------------------------------------------------
module mic_axi_sample_writer #(
    parameter int                    ADDR_WIDTH = 24,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 24'h000004,
    parameter int                    NUM_WORDS  = 1024,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  S_AXI_ARESETN,
    input  logic                  start,
    input  logic [15:0]           sample_data,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  wr_err,
    output logic [15:0]           words_written,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [7:0]            M_AXI_AWLEN,
    output logic [2:0]            M_AXI_AWSIZE,
    output logic [1:0]            M_AXI_AWBURST,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [31:0]           M_AXI_WDATA,
    output logic [3:0]            M_AXI_WSTRB,
    output logic                  M_AXI_WLAST,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY
);

    localparam int              PTR_W         = $clog2(FIFO_DEPTH);
    localparam logic [16:0]     TOTAL_SAMPLES = 17'(2 * NUM_WORDS);
    localparam logic [15:0]     LAST_COUNT    = 16'(NUM_WORDS);
    localparam logic [PTR_W:0]  FULL_COUNT    = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic       {C_IDLE, C_RUN}          ctrl_state_t;
    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wr_state_t;

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    ctrl_state_t            ctrl_q, ctrl_d;
    wr_state_t              wr_q, wr_d;

    logic [16:0]            samples_acc_q, samples_acc_d;
    logic                   half_q, half_d;           // 1: low half already held
    logic [15:0]            pack_lo_q, pack_lo_d;
    logic                   overflow_q, overflow_d;
    logic                   wr_err_q, wr_err_d;
    logic [15:0]            words_written_q, words_written_d;
    logic [ADDR_WIDTH-1:0]  next_addr_q, next_addr_d;

    logic [31:0]            fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         count_q, count_d;

    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;
    logic [31:0]            wdata_q, wdata_d;

    // ------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------
    logic running, fifo_empty, fifo_full, room_left;
    logic start_rec, rec_done, sample_hs, push, pop;
    logic aw_fin, w_fin;

    assign running    = (ctrl_q == C_RUN);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_COUNT);
    assign room_left  = (samples_acc_q < TOTAL_SAMPLES);
    assign start_rec  = (ctrl_q == C_IDLE) && start;
    assign rec_done   = running && (words_written_q == LAST_COUNT);
    assign sample_hs  = sample_valid && sample_ready;
    assign push       = sample_hs && half_q;
    assign pop        = (wr_q == W_RESP) && M_AXI_BVALID;
    // A channel counts as finished if it completed earlier or completes now.
    assign aw_fin     = aw_done_q || M_AXI_AWREADY;
    assign w_fin      = w_done_q  || M_AXI_WREADY;

    // ------------------------------------------------------------------
    // Control FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl_q <= C_IDLE;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        case (ctrl_q)
            C_IDLE:  if (start)    ctrl_d = C_RUN;
            C_RUN:   if (rec_done) ctrl_d = C_IDLE;
            default: ctrl_d = C_IDLE;
        endcase
    end

    always_comb begin
        busy         = running;
        done         = rec_done;
        sample_ready = running && !fifo_full && room_left;
    end

    // ------------------------------------------------------------------
    // Sample packing, status and address bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        samples_acc_d   = samples_acc_q;
        half_d          = half_q;
        pack_lo_d       = pack_lo_q;
        overflow_d      = overflow_q;
        wr_err_d        = wr_err_q;
        words_written_d = words_written_q;
        next_addr_d     = next_addr_q;

        if (start_rec) begin
            samples_acc_d   = '0;
            half_d          = 1'b0;
            overflow_d      = 1'b0;
            wr_err_d        = 1'b0;
            words_written_d = '0;
            next_addr_d     = BASE_ADDR;
        end else begin
            if (sample_hs) begin
                samples_acc_d = samples_acc_q + 17'd1;
                half_d        = !half_q;
                if (!half_q) pack_lo_d = sample_data;
            end
            // Refusals after the recording is full are expected, not overflow.
            if (running && sample_valid && !sample_ready && room_left) begin
                overflow_d = 1'b1;
            end
            if (pop) begin
                words_written_d = words_written_q + 16'd1;
                next_addr_d     = next_addr_q + ADDR_WIDTH'(4);
                if (M_AXI_BRESP != 2'b00) wr_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            samples_acc_q   <= '0;
            half_q          <= 1'b0;
            pack_lo_q       <= '0;
            overflow_q      <= 1'b0;
            wr_err_q        <= 1'b0;
            words_written_q <= '0;
            next_addr_q     <= BASE_ADDR;
        end else begin
            samples_acc_q   <= samples_acc_d;
            half_q          <= half_d;
            pack_lo_q       <= pack_lo_d;
            overflow_q      <= overflow_d;
            wr_err_q        <= wr_err_d;
            words_written_q <= words_written_d;
            next_addr_q     <= next_addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Packed-word FIFO. The head stays in place until its write response
    // arrives, so the word is only released once it is known to be written.
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once count says valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {sample_data, pack_lo_q};
    end

    // ------------------------------------------------------------------
    // Write FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_q      <= W_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wdata_q   <= '0;
        end else begin
            wr_q      <= wr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        wr_d      = wr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        wdata_d   = wdata_q;
        case (wr_q)
            W_IDLE: begin
                if (!fifo_empty) begin
                    wr_d      = W_XFER;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    // Registered copy of the head keeps WDATA stable in W_XFER.
                    wdata_d   = fifo_mem_q[rd_ptr_q];
                end
            end
            W_XFER: begin
                aw_done_d = aw_fin;
                w_done_d  = w_fin;
                if (aw_fin && w_fin) wr_d = W_RESP;
            end
            W_RESP: begin
                if (M_AXI_BVALID) wr_d = W_IDLE;
            end
            default: wr_d = W_IDLE;
        endcase
    end

    always_comb begin
        M_AXI_AWVALID = (wr_q == W_XFER) && !aw_done_q;
        M_AXI_WVALID  = (wr_q == W_XFER) && !w_done_q;
        M_AXI_BREADY  = (wr_q == W_RESP);
    end

    // ------------------------------------------------------------------
    // Remaining outputs
    // ------------------------------------------------------------------
    assign overflow      = overflow_q;
    assign wr_err        = wr_err_q;
    assign words_written = words_written_q;
    assign M_AXI_AWADDR  = next_addr_q;
    assign M_AXI_AWLEN   = 8'd0;
    assign M_AXI_AWSIZE  = 3'b010;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WLAST   = 1'b1;

endmodule

// File: tb/tb_mic_axi_sample_writer.sv
`timescale 1ns/1ps
// Bench for mic_axi_sample_writer. Two instances share the stimulus: dut_a
// records 2 words, dut_b records 6 words (needed to fill the 4-entry FIFO).
// Only the selected instance ever sees start, so the other stays idle.
module tb_mic_axi_sample_writer;

    localparam logic [23:0] BASE = 24'h000004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic [15:0] sample_data = '0;
    logic        sample_valid = 1'b0;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [1:0]  bresp = 2'b00;

    always #5 clk = ~clk;

    logic start_a, start_b;
    assign start_a = start && !sel;
    assign start_b = start && sel;

    logic        a_sready, a_busy, a_done, a_ovf, a_err, a_awv, a_wv, a_br, a_wlast;
    logic        b_sready, b_busy, b_done, b_ovf, b_err, b_awv, b_wv, b_br, b_wlast;
    logic [15:0] a_ww, b_ww;
    logic [23:0] a_awaddr, b_awaddr;
    logic [7:0]  a_awlen, b_awlen;
    logic [2:0]  a_awsize, b_awsize;
    logic [1:0]  a_awburst, b_awburst;
    logic [31:0] a_wdata, b_wdata;
    logic [3:0]  a_wstrb, b_wstrb;

    mic_axi_sample_writer #(.ADDR_WIDTH(24), .BASE_ADDR(BASE), .NUM_WORDS(2), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .S_AXI_ARESETN(rst_n), .start(start_a),
        .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(a_sready),
        .busy(a_busy), .done(a_done), .overflow(a_ovf), .wr_err(a_err), .words_written(a_ww),
        .M_AXI_AWADDR(a_awaddr), .M_AXI_AWLEN(a_awlen), .M_AXI_AWSIZE(a_awsize),
        .M_AXI_AWBURST(a_awburst), .M_AXI_AWVALID(a_awv), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(a_wdata), .M_AXI_WSTRB(a_wstrb), .M_AXI_WLAST(a_wlast),
        .M_AXI_WVALID(a_wv), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(a_br));

    mic_axi_sample_writer #(.ADDR_WIDTH(24), .BASE_ADDR(BASE), .NUM_WORDS(6), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .S_AXI_ARESETN(rst_n), .start(start_b),
        .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(b_sready),
        .busy(b_busy), .done(b_done), .overflow(b_ovf), .wr_err(b_err), .words_written(b_ww),
        .M_AXI_AWADDR(b_awaddr), .M_AXI_AWLEN(b_awlen), .M_AXI_AWSIZE(b_awsize),
        .M_AXI_AWBURST(b_awburst), .M_AXI_AWVALID(b_awv), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(b_wdata), .M_AXI_WSTRB(b_wstrb), .M_AXI_WLAST(b_wlast),
        .M_AXI_WVALID(b_wv), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(b_br));

    // Outputs of the selected instance
    logic        s_sready, s_busy, s_done, s_ovf, s_err, s_awv, s_wv, s_br;
    logic [15:0] s_ww;
    logic [23:0] s_awaddr;
    logic [31:0] s_wdata;
    assign s_sready = sel ? b_sready : a_sready;
    assign s_busy   = sel ? b_busy   : a_busy;
    assign s_done   = sel ? b_done   : a_done;
    assign s_ovf    = sel ? b_ovf    : a_ovf;
    assign s_err    = sel ? b_err    : a_err;
    assign s_awv    = sel ? b_awv    : a_awv;
    assign s_wv     = sel ? b_wv     : a_wv;
    assign s_br     = sel ? b_br     : a_br;
    assign s_ww     = sel ? b_ww     : a_ww;
    assign s_awaddr = sel ? b_awaddr : a_awaddr;
    assign s_wdata  = sel ? b_wdata  : a_wdata;

    // ------------------------------------------------------------------
    // Counters and check helper
    // ------------------------------------------------------------------
    int pass_cnt = 0;
    int check_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [23:0] addr;
        logic [31:0] data;
        int          aw_cyc;
    } exp_t;
    exp_t exp_q[$];

    int aw_delay = 0;   // cycles AWREADY is held low once AWVALID is seen
    int b_delay  = 0;   // cycles before BVALID is raised
    int err_idx  = -1;  // response index that gets SLVERR
    int exp_idx  = 0;

    task automatic push_word(input logic [15:0] lo, input logic [15:0] hi);
        exp_t e;
        e.addr   = BASE + 24'(4 * exp_idx);
        e.data   = {hi, lo};
        e.aw_cyc = aw_delay + 1;
        exp_q.push_back(e);
        exp_idx++;
    endtask

    // ------------------------------------------------------------------
    // Slave model and monitor: drives READY/B at negedge, records the
    // transfer and compares it against the queue when the B handshake fires.
    // ------------------------------------------------------------------
    int          done_cnt = 0, b_count = 0, b_idx = 0;
    logic        aw_got, w_got, b_pend, aw_unstable;
    int          aw_wait, b_wait, aw_cyc, w_cyc;
    logic [23:0] cap_addr, hold_addr;
    logic [31:0] cap_data;
    exp_t        cur;

    initial begin : slave_monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
                aw_got = 0; w_got = 0; b_pend = 0; aw_unstable = 0;
                aw_wait = 0; b_wait = 0; aw_cyc = 0; w_cyc = 0;
            end else begin
                if (s_done) done_cnt++;
                awready = 0;
                if (s_awv && !aw_got) begin
                    if (aw_cyc == 0) hold_addr = s_awaddr;
                    else if (s_awaddr != hold_addr) aw_unstable = 1;
                    aw_cyc++;
                    if (aw_wait >= aw_delay) begin
                        awready = 1; aw_got = 1; cap_addr = s_awaddr;
                    end else aw_wait++;
                end
                wready = 0;
                if (s_wv && !w_got) begin
                    w_cyc++;
                    wready = 1; w_got = 1; cap_data = s_wdata;
                end
                bvalid = 0;
                if (b_pend) begin
                    if (b_wait >= b_delay) begin
                        bvalid = 1;
                        bresp  = (b_idx == err_idx) ? 2'b10 : 2'b00;
                        if (s_br) begin
                            $display("write %0d: addr=%06h data=%08h bresp=%0d", b_count, cap_addr, cap_data, bresp);
                            check("sb_expected", 32'(exp_q.size() > 0), 32'd1);
                            if (exp_q.size() > 0) begin
                                cur = exp_q.pop_front();
                                check("awaddr", 32'(cap_addr), 32'(cur.addr));
                                check("wdata", cap_data, cur.data);
                                check("awvalid_cycles", 32'(aw_cyc), 32'(cur.aw_cyc));
                                check("wvalid_cycles", 32'(w_cyc), 32'd1);
                                check("awaddr_stable", 32'(aw_unstable), 32'd0);
                            end
                            b_count++; b_idx++;
                            b_pend = 0; aw_got = 0; w_got = 0; aw_unstable = 0;
                            aw_wait = 0; aw_cyc = 0; w_cyc = 0;
                        end
                    end else b_wait++;
                end else if (aw_got && w_got) begin
                    b_pend = 1; b_wait = 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all called just after a negedge)
    // ------------------------------------------------------------------
    task automatic start_pulse();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic send(input logic [15:0] d);
        int n = 0;
        sample_data  = d;
        sample_valid = 1;
        while (!s_sready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_sready) check("send_timeout", 32'(s_sready), 32'd1);
        @(negedge clk);
        sample_valid = 0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (s_busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (s_busy) check("idle_timeout", 32'(s_busy), 32'd0);
        @(negedge clk);
    endtask

    int d0, b0;

    initial begin
        // ---- reset values ----
        repeat (3) @(negedge clk);
        check("rst_awaddr", 32'(a_awaddr), 32'(BASE));
        check("rst_awvalid", 32'(a_awv), 0);
        check("rst_wvalid", 32'(a_wv), 0);
        check("rst_bready", 32'(a_br), 0);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_sready", 32'(a_sready), 0);
        check("rst_ww", 32'(a_ww), 0);
        check("rst_wdata", a_wdata, 0);
        check("const_awlen", 32'(a_awlen), 0);
        check("const_awsize", 32'(a_awsize), 2);
        check("const_awburst", 32'(a_awburst), 1);
        check("const_wstrb", 32'(a_wstrb), 32'hF);
        check("const_wlast", 32'(a_wlast), 1);
        rst_n = 1;
        @(negedge clk);

        // ---- 1: basic 2-word recording, always-ready slave ----
        exp_idx = 0; d0 = done_cnt; b0 = b_count;
        push_word(16'h1111, 16'h2222);
        push_word(16'h3333, 16'h4444);
        start_pulse();
        send(16'h1111); send(16'h2222); send(16'h3333); send(16'h4444);
        wait_idle(200);
        check("t1_done_pulses", 32'(done_cnt - d0), 1);
        check("t1_b_count", 32'(b_count - b0), 2);
        check("t1_ww", 32'(s_ww), 2);
        check("t1_busy", 32'(s_busy), 0);
        check("t1_overflow", 32'(s_ovf), 0);
        check("t1_drained", 32'(exp_q.size()), 0);

        // ---- 2: AWREADY held low 5 cycles ----
        aw_delay = 5; exp_idx = 0; d0 = done_cnt; b0 = b_count;
        push_word(16'hA1A1, 16'hB2B2);
        push_word(16'hC3C3, 16'hD4D4);
        start_pulse();
        send(16'hA1A1); send(16'hB2B2); send(16'hC3C3); send(16'hD4D4);
        wait_idle(300);
        check("t2_b_count", 32'(b_count - b0), 2);
        check("t2_done_pulses", 32'(done_cnt - d0), 1);
        check("t2_drained", 32'(exp_q.size()), 0);
        aw_delay = 0;

        // ---- 3: BVALID stalled 20 cycles, continuous samples, 6-word DUT ----
        sel = 1; b_delay = 20; exp_idx = 0; d0 = done_cnt;
        for (int i = 0; i < 6; i++) push_word(16'(16'h5000 + 2 * i), 16'(16'h5001 + 2 * i));
        start_pulse();
        for (int i = 0; i < 8; i++) send(16'(16'h5000 + i));
        check("t3_fifo_full_sready", 32'(s_sready), 0);
        check("t3_no_overflow_yet", 32'(s_ovf), 0);
        for (int i = 8; i < 12; i++) send(16'(16'h5000 + i));
        wait_idle(2000);
        check("t3_overflow", 32'(s_ovf), 1);
        check("t3_ww", 32'(s_ww), 6);
        check("t3_done_pulses", 32'(done_cnt - d0), 1);
        check("t3_drained", 32'(exp_q.size()), 0);
        sel = 0; b_delay = 0;

        // ---- 4: SLVERR on word 0 ----
        err_idx = 0; b_idx = 0; exp_idx = 0;
        push_word(16'h0101, 16'h0202);
        push_word(16'h0303, 16'h0404);
        start_pulse();
        send(16'h0101); send(16'h0202); send(16'h0303); send(16'h0404);
        wait_idle(200);
        check("t4_wr_err", 32'(s_err), 1);
        check("t4_ww", 32'(s_ww), 2);
        err_idx = -1; exp_idx = 0;
        push_word(16'h0505, 16'h0606);
        push_word(16'h0707, 16'h0808);
        start_pulse();
        check("t4_err_cleared", 32'(s_err), 0);
        check("t4_ww_cleared", 32'(s_ww), 0);
        send(16'h0505); send(16'h0606); send(16'h0707); send(16'h0808);
        wait_idle(200);
        check("t4_err_clean_run", 32'(s_err), 0);
        check("t4_drained", 32'(exp_q.size()), 0);

        // ---- 5: reset during W_XFER ----
        aw_delay = 10; exp_idx = 0;
        push_word(16'hDEAD, 16'hBEEF);
        start_pulse();
        send(16'hDEAD); send(16'hBEEF);
        for (int n = 0; n < 20 && !s_awv; n++) @(negedge clk);
        check("t5_in_xfer", 32'(s_awv), 1);
        #2 rst_n = 0;
        #1;
        check("t5_rst_awvalid", 32'(s_awv), 0);
        check("t5_rst_wvalid", 32'(s_wv), 0);
        check("t5_rst_busy", 32'(s_busy), 0);
        check("t5_rst_awaddr", 32'(s_awaddr), 32'(BASE));
        repeat (2) @(negedge clk);
        exp_q.delete();
        aw_delay = 0; exp_idx = 0; d0 = done_cnt;
        rst_n = 1;
        @(negedge clk);
        push_word(16'h1234, 16'h5678);
        push_word(16'h9ABC, 16'hDEF0);
        start_pulse();
        send(16'h1234); send(16'h5678); send(16'h9ABC); send(16'hDEF0);
        wait_idle(200);
        check("t5_ww", 32'(s_ww), 2);
        check("t5_done_pulses", 32'(done_cnt - d0), 1);
        check("t5_drained", 32'(exp_q.size()), 0);

        // ---- 6: start while busy, extra sample after the last one ----
        exp_idx = 0; d0 = done_cnt;
        push_word(16'h6161, 16'h6262);
        push_word(16'h6363, 16'h6464);
        start_pulse();
        send(16'h6161); send(16'h6262);
        start_pulse();
        send(16'h6363); send(16'h6464);
        sample_data = 16'h6565;
        sample_valid = 1;
        check("t6_sready_after_limit", 32'(s_sready), 0);
        @(negedge clk);
        sample_valid = 0;
        wait_idle(200);
        check("t6_overflow", 32'(s_ovf), 0);
        check("t6_ww", 32'(s_ww), 2);
        check("t6_done_pulses", 32'(done_cnt - d0), 1);
        check("t6_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
